// File: rtl/perspective_divider_if.sv
// Triangle types and the handshake interface for the perspective-divide stage.
// The divider uses modport slave; the upstream/downstream environment uses modport master.
package perspective_divider_pkg;

    typedef struct packed {
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] z;
    } pos_t;

    typedef struct packed {
        pos_t        pos;
        logic [31:0] color;
    } vertex_t;

    typedef struct packed {
        logic [15:0]    tri_id;
        vertex_t [2:0]  v;
    } triangle_t;

endpackage

interface perspective_divider_if;
    import perspective_divider_pkg::*;

    triangle_t triangle;
    logic      in_valid;
    logic      in_ready;
    triangle_t out_triangle;
    logic      out_valid;
    logic      out_ready;
    logic      busy;

    modport master (
        output triangle,
        output in_valid,
        output out_ready,
        input  in_ready,
        input  out_triangle,
        input  out_valid,
        input  busy
    );

    modport slave (
        input  triangle,
        input  in_valid,
        input  out_ready,
        output in_ready,
        output out_triangle,
        output out_valid,
        output busy
    );

endinterface

// File: rtl/perspective_divider.sv
// Perspective divide: x' = x/d, y' = y/d with d = -z per vertex, Q16.16, iterative restoring divider.
// Define PERSP_NEAR_CULL_EN to drop triangles with any vertex closer than Z_MIN instead of clamping.
module perspective_divider
    import perspective_divider_pkg::*;
#(
    parameter int          DIV_BITS_PER_CYCLE = 1,
    parameter logic [31:0] Z_MIN              = 32'h0000_0100
) (
    input  logic                 clk,
    input  logic                 rst_n,
    perspective_divider_if.slave bus
);

    localparam int         STEPS     = 32 / DIV_BITS_PER_CYCLE;
    localparam logic [5:0] LAST_STEP = 6'(STEPS - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        DIVIDE,
        OUTPUT
    } state_t;

    state_t      state;
    state_t      state_nx;

    triangle_t   result;
    logic [1:0]  vidx;
    logic [5:0]  cnt;
    logic [31:0] div_d;
    logic [31:0] rem_x;
    logic [31:0] rem_y;
    logic [31:0] sh_x;
    logic [31:0] sh_y;
    logic        neg_x;
    logic        neg_y;
    logic        ovf_x;
    logic        ovf_y;

    logic [31:0] rem_x_nx;
    logic [31:0] rem_y_nx;
    logic [31:0] sh_x_nx;
    logic [31:0] sh_y_nx;

    logic [31:0] cur_x;
    logic [31:0] cur_y;
    logic [31:0] cur_z;
    logic [31:0] abs_x;
    logic [31:0] abs_y;
    logic [31:0] setup_d;
    logic        last_step;
    logic        cull;

    // d is formed in 33 bits so z = -2^31 yields +2^31 rather than wrapping negative.
    function automatic logic [31:0] divisor_of(input logic [31:0] z);
        logic signed [32:0] d;
        d = -$signed({z[31], z});
        if (d < $signed({1'b0, Z_MIN})) begin
            return Z_MIN;
        end
        return d[31:0];
    endfunction

    function automatic logic [31:0] magnitude(input logic [31:0] n);
        return n[31] ? (~n + 32'd1) : n;
    endfunction

    // One restoring step: the shift register feeds dividend bits out the top and quotient bits in the bottom.
    function automatic logic [63:0] div_step(input logic [31:0] rem, input logic [31:0] sh,
                                             input logic [31:0] d);
        logic [32:0] trial;
        logic [32:0] diff;
        trial = {rem, sh[31]};
        diff  = trial - {1'b0, d};
        if (trial >= {1'b0, d}) begin
            return {32'(diff), sh[30:0], 1'b1};
        end
        return {32'(trial), sh[30:0], 1'b0};
    endfunction

    function automatic logic [31:0] signed_result(input logic [31:0] q, input logic neg,
                                                  input logic ovf);
        if (ovf) begin
            return neg ? 32'h8000_0001 : 32'h7FFF_FFFF;
        end
        return neg ? -q : q;
    endfunction

    assign cur_x     = result.v[vidx].pos.x;
    assign cur_y     = result.v[vidx].pos.y;
    assign cur_z     = result.v[vidx].pos.z;
    assign abs_x     = magnitude(cur_x);
    assign abs_y     = magnitude(cur_y);
    assign setup_d   = divisor_of(cur_z);
    assign last_step = (cnt == LAST_STEP);

`ifdef PERSP_NEAR_CULL_EN
    function automatic logic too_near(input logic [31:0] z);
        logic signed [32:0] d;
        d = -$signed({z[31], z});
        return d < $signed({1'b0, Z_MIN});
    endfunction

    assign cull = (vidx == 2'd0) && (too_near(result.v[0].pos.z) ||
                                     too_near(result.v[1].pos.z) ||
                                     too_near(result.v[2].pos.z));
`else
    assign cull = 1'b0;
`endif

    always_comb begin
        rem_x_nx = rem_x;
        rem_y_nx = rem_y;
        sh_x_nx  = sh_x;
        sh_y_nx  = sh_y;
        for (int i = 0; i < DIV_BITS_PER_CYCLE; i++) begin
            {rem_x_nx, sh_x_nx} = div_step(rem_x_nx, sh_x_nx, div_d);
            {rem_y_nx, sh_y_nx} = div_step(rem_y_nx, sh_y_nx, div_d);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    state_nx = SETUP;
                end
            end
            SETUP: begin
                state_nx = cull ? IDLE : DIVIDE;
            end
            DIVIDE: begin
                if (last_step) begin
                    state_nx = (vidx == 2'd2) ? OUTPUT : SETUP;
                end
            end
            OUTPUT: begin
                if (bus.out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // The accepted triangle is copied straight into the result so z and attributes pass through.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result <= '0;
            vidx   <= 2'd0;
            cnt    <= 6'd0;
            div_d  <= 32'd0;
            rem_x  <= 32'd0;
            rem_y  <= 32'd0;
            sh_x   <= 32'd0;
            sh_y   <= 32'd0;
            neg_x  <= 1'b0;
            neg_y  <= 1'b0;
            ovf_x  <= 1'b0;
            ovf_y  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        result <= bus.triangle;
                        vidx   <= 2'd0;
                    end
                end
                SETUP: begin
                    div_d <= setup_d;
                    rem_x <= {16'd0, abs_x[31:16]};
                    rem_y <= {16'd0, abs_y[31:16]};
                    sh_x  <= {abs_x[15:0], 16'd0};
                    sh_y  <= {abs_y[15:0], 16'd0};
                    neg_x <= cur_x[31];
                    neg_y <= cur_y[31];
                    ovf_x <= (abs_x >> 15) >= setup_d;
                    ovf_y <= (abs_y >> 15) >= setup_d;
                    cnt   <= 6'd0;
                end
                DIVIDE: begin
                    rem_x <= rem_x_nx;
                    rem_y <= rem_y_nx;
                    sh_x  <= sh_x_nx;
                    sh_y  <= sh_y_nx;
                    cnt   <= cnt + 6'd1;
                    if (last_step) begin
                        result.v[vidx].pos.x <= signed_result(sh_x_nx, neg_x, ovf_x);
                        result.v[vidx].pos.y <= signed_result(sh_y_nx, neg_y, ovf_y);
                        vidx                 <= vidx + 2'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.in_ready     = (state == IDLE);
    assign bus.out_valid    = (state == OUTPUT);
    assign bus.busy         = (state != IDLE);
    assign bus.out_triangle = result;

endmodule
